// File: rtl/normal_matrix_memory.sv
// XF normal matrix store: 32 rows x 3 lanes x 32-bit floats, cleared by a sweep after reset,
// written per word from the register-load path and read per row with a two-cycle latency.
module normal_matrix_memory (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  nommatAddr,
    input  logic        nommatEnable,
    output logic [95:0] nommatData,
    output logic        nommatValid,
    input  logic [6:0]  wrAddr,
    input  logic [31:0] wrData,
    input  logic        wrEnable,
    output logic        wrAck,
    output logic        wrError,
    output logic        initDone
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_r;
    logic [4:0]  clr_cnt_r;

    logic [31:0] lane0_r [0:31];
    logic [31:0] lane1_r [0:31];
    logic [31:0] lane2_r [0:31];

    logic [4:0]  wr_row_s;
    logic [1:0]  wr_lane_s;
    logic        wr_ok_s;
    logic [2:0]  lane_we_s;
    logic [4:0]  lane_row_s;
    logic [31:0] lane_wd_s;

    logic [95:0] s1_data_r;
    logic        s1_valid_r;
    logic [95:0] s2_data_r;
    logic        s2_valid_r;

    // Word decode and lane write-enable selection; the clear sweep owns the array during INIT.
    always_comb begin
        wr_row_s   = 5'(wrAddr / 7'd3);
        wr_lane_s  = 2'(wrAddr % 7'd3);
        wr_ok_s    = resetn && wrEnable && (state_r == ST_RUN) && (wrAddr <= 7'd95);
        lane_we_s  = 3'b000;
        lane_row_s = 5'd0;
        lane_wd_s  = 32'd0;
        if (state_r == ST_INIT) begin
            lane_row_s = clr_cnt_r;
            lane_wd_s  = 32'd0;
            lane_we_s  = {3{resetn}};
        end else begin
            lane_row_s = wr_row_s;
            lane_wd_s  = wrData;
            case (wr_lane_s)
                2'd0:    lane_we_s = {2'b00, wr_ok_s};
                2'd1:    lane_we_s = {1'b0, wr_ok_s, 1'b0};
                2'd2:    lane_we_s = {wr_ok_s, 2'b00};
                default: lane_we_s = 3'b000;
            endcase
        end
    end

    // Array storage: one write port per lane, no reset (the sweep clears it).
    always_ff @(posedge clk) begin
        if (lane_we_s[0]) lane0_r[lane_row_s] <= lane_wd_s;
        if (lane_we_s[1]) lane1_r[lane_row_s] <= lane_wd_s;
        if (lane_we_s[2]) lane2_r[lane_row_s] <= lane_wd_s;
    end

    // Clear-sweep sequencer and initDone flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_INIT;
            clr_cnt_r <= 5'd0;
            initDone  <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    clr_cnt_r <= clr_cnt_r + 5'd1;
                    if (clr_cnt_r == 5'd31) begin
                        state_r  <= ST_RUN;
                        initDone <= 1'b1;
                    end else begin
                        state_r  <= ST_INIT;
                        initDone <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r  <= ST_RUN;
                    initDone <= 1'b1;
                end
                default: begin
                    state_r   <= ST_INIT;
                    clr_cnt_r <= 5'd0;
                    initDone  <= 1'b0;
                end
            endcase
        end
    end

    // Write response pulses, exactly one per write strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrAck   <= 1'b0;
            wrError <= 1'b0;
        end else begin
            wrAck   <= wr_ok_s;
            wrError <= wrEnable && !wr_ok_s;
        end
    end

    // Read pipeline: the row is captured at the request edge, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        s1_data_r <= {lane0_r[nommatAddr], lane1_r[nommatAddr], lane2_r[nommatAddr]};
        s2_data_r <= s1_data_r;
        if (!resetn) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            nommatValid <= 1'b0;
            nommatData  <= 96'd0;
        end else begin
            s1_valid_r  <= nommatEnable;
            s2_valid_r  <= s1_valid_r;
            nommatValid <= s2_valid_r;
            if (s2_valid_r) nommatData <= s2_data_r;
            else            nommatData <= nommatData;
        end
    end

endmodule

// File: tb/tb_normal_matrix_memory.sv
// Randomised self-checking bench for normal_matrix_memory against a word-array reference model.
module tb_normal_matrix_memory;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  nommatAddr;
    logic        nommatEnable;
    logic [95:0] nommatData;
    logic        nommatValid;
    logic [6:0]  wrAddr;
    logic [31:0] wrData;
    logic        wrEnable;
    logic        wrAck;
    logic        wrError;
    logic        initDone;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    normal_matrix_memory dut (
        .clk(clk), .resetn(resetn),
        .nommatAddr(nommatAddr), .nommatEnable(nommatEnable),
        .nommatData(nommatData), .nommatValid(nommatValid),
        .wrAddr(wrAddr), .wrData(wrData), .wrEnable(wrEnable),
        .wrAck(wrAck), .wrError(wrError), .initDone(initDone)
    );

    // Reference model: flat 96-word array, cycles since reset release, pending responses by edge.
    logic [31:0] mdl [0:95];
    int          hi_cnt  = 0;
    int          edge_n  = 0;
    bit          started = 0;
    bit          pv [0:3];
    logic [95:0] pd [0:3];
    logic [95:0] last_data;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] mrow(input int r);
        return {mdl[3*r], mdl[3*r+1], mdl[3*r+2]};
    endfunction

    task automatic drive(input bit en, input int ra, input bit we, input int wa, input logic [31:0] wd);
        nommatEnable = en;
        nommatAddr   = 5'(ra);
        wrEnable     = we;
        wrAddr       = 7'(wa);
        wrData       = wd;
    endtask

    task automatic cyc();
        int  slot;
        bit  exp_ack;
        bit  exp_err;
        @(posedge clk);
        #1;
        edge_n++;
        if (!resetn) begin
            started   = 1;
            hi_cnt    = 0;
            last_data = 96'd0;
            for (int i = 0; i < 4; i++) pv[i] = 0;
            check_val("rst_valid", {95'd0, nommatValid}, 96'd0);
            check_val("rst_data", nommatData, 96'd0);
            check_val("rst_ack", {95'd0, wrAck}, 96'd0);
            check_val("rst_err", {95'd0, wrError}, 96'd0);
            check_val("rst_initdone", {95'd0, initDone}, 96'd0);
        end else if (started) begin
            hi_cnt++;
            slot = edge_n % 4;
            check_val("rd_valid", {95'd0, nommatValid}, {95'd0, pv[slot]});
            if (pv[slot]) last_data = pd[slot];
            check_val("rd_data", nommatData, last_data);
            pv[slot] = 0;
            if (nommatEnable) begin
                pv[(edge_n + 2) % 4] = 1;
                pd[(edge_n + 2) % 4] = mrow(int'(nommatAddr));
            end
            exp_ack = wrEnable && (hi_cnt >= 33) && (wrAddr < 7'd96);
            exp_err = wrEnable && !exp_ack;
            check_val("wr_ack", {95'd0, wrAck}, {95'd0, exp_ack});
            check_val("wr_err", {95'd0, wrError}, {95'd0, exp_err});
            check_val("initdone", {95'd0, initDone}, {95'd0, (hi_cnt >= 32)});
            if (hi_cnt <= 32) begin
                for (int l = 0; l < 3; l++) mdl[3*(hi_cnt-1) + l] = 32'd0;
            end else if (exp_ack) begin
                mdl[int'(wrAddr)] = wrData;
            end
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0, 0, 32'd0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_reset();
        drive(1'b0, 0, 1'b0, 0, 32'd0);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 96; i++) mdl[i] = 32'hx;
        drive(1'b0, 0, 1'b0, 0, 32'd0);
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        idle(40);

        // Preload, then reset with a write issued during the sweep.
        for (int w = 0; w < 96; w++) begin
            drive(1'b0, 0, 1'b1, w, 32'h1000 + 32'(w));
            cyc();
        end
        pulse_reset();
        drive(1'b0, 0, 1'b1, 10, 32'hDEAD_BEEF);
        cyc();
        idle(32);
        for (int r = 0; r < 32; r++) begin
            drive(1'b1, r, 1'b0, 0, 32'd0);
            cyc();
        end
        idle(3);

        // Word packing: word 4 lands in row 1, lane 1.
        drive(1'b0, 0, 1'b1, 4, 32'h3F80_0000);
        cyc();
        drive(1'b1, 1, 1'b0, 0, 32'd0);
        cyc();
        idle(2);
        check_val("pack_valid", {95'd0, nommatValid}, 96'd1);
        check_val("pack_data", nommatData, {32'h0, 32'h3F80_0000, 32'h0});

        // Fill with index values, then a 3-row burst.
        for (int w = 0; w < 96; w++) begin
            drive(1'b0, 0, 1'b1, w, 32'(w));
            cyc();
        end
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, r, 1'b0, 0, 32'd0);
            cyc();
        end
        idle(3);

        // Same-row hazard on word 6.
        drive(1'b0, 0, 1'b1, 6, 32'd5);
        cyc();
        drive(1'b1, 2, 1'b1, 6, 32'hAA);
        cyc();
        drive(1'b1, 2, 1'b0, 0, 32'd0);
        cyc();
        idle(1);
        check_val("hazard_old", {64'd0, nommatData[95:64]}, 96'd5);
        idle(1);
        check_val("hazard_new", {64'd0, nommatData[95:64]}, 96'hAA);
        idle(1);

        // Out-of-range write.
        drive(1'b0, 0, 1'b1, 96, 32'hFFFF_FFFF);
        cyc();
        check_val("oor_err", {95'd0, wrError}, 96'd1);
        check_val("oor_ack", {95'd0, wrAck}, 96'd0);
        idle(1);

        // Random mixed traffic, including out-of-range writes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), $urandom);
            cyc();
        end
        idle(3);

        // Mid-burst reset: in-flight reads are discarded.
        drive(1'b1, 3, 1'b0, 0, 32'd0);
        cyc();
        drive(1'b1, 4, 1'b0, 0, 32'd0);
        cyc();
        pulse_reset();
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
